dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Single-clock sequencer and two-port round-robin arbiter for the two-phase `DRAM` macro. It accepts read/write requests from port 0 (instruction fetch) and port 1 (load/store). For each granted request it generates the DRAM address-latch strobe (`mem_clk2`), the access strobe (`mem_clk1`) and `RD`/`WR`, then returns read data with a one-cycle acknowledge. It sits between the core's fetch/memory stages and the `DRAM` instance.

## Interface
- `WordSize`, default 16: data width; must match `DRAM`.
- `AddrWidth`, default 16: address width; must match `DRAM`.

Ports:
- `clk`  in  1  system clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  request level; held until the matching ack.
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while req is high.
- `addr0`, `addr1`  in  AddrWidth  request address; stable while req is high.
- `wdata0`, `wdata1`  in  WordSize  write data; stable while req is high.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  WordSize  read data; valid with ack, held until that port's next read completes.
- `mem_addr`  out  AddrWidth  to `DRAM.Addr`.
- `mem_din`  out  WordSize  to `DRAM.DataIn`.
- `mem_dout`  in  WordSize  from `DRAM.DataOut`.
- `mem_clk1`, `mem_clk2`  out  1  access and address-latch strobes.
- `mem_rd`, `mem_wr`  out  1  to `DRAM.RD` / `DRAM.WR`.

## Operation
- All outputs are registered, so strobes are glitch-free.
- FSM states: IDLE, ADDR, LATCH, CMD, STROBE, DONE.
- IDLE
  - No req: stay in IDLE.
  - Any req: arbitrate, register the winner's addr, we and wdata into `mem_addr`, `mem_din` and an internal `sel`/`we_q`, then go to ADDR.
- ADDR: address stable, all strobes 0. Go to LATCH. This cycle keeps the address change off the strobe edge.
- LATCH: `mem_clk2`=1, so the DRAM latches the address. Go to CMD.
- CMD: `mem_clk2`=0. `mem_rd`=~we_q and `mem_wr`=we_q. Go to STROBE.
- STROBE: `mem_clk1`=1, rd/wr held, so the DRAM performs the access. At the exit edge, capture `mem_dout` into `rdata[sel]` on a read only. Go to DONE.
- DONE
  - `mem_clk1`=0 and rd/wr held.
  - `ack[sel]`=1 for this cycle only.
  - Go to IDLE.
- `mem_addr` and `mem_din` are held from ADDR through DONE. In IDLE they keep their last values.
- `mem_rd` and `mem_wr` are 0 in IDLE, ADDR, LATCH. They are never both 1.
- Arbitration
  - `last` is a 1-bit pointer to the most recently granted port.
  - Single requester: that requester wins.
  - Both requesting: the port ≠ `last` wins.
  - `last` updates at the grant edge. After reset `last`=1, so port 0 wins the first tie.
- Requests are sampled only in IDLE. A req that rises mid-transaction waits.
- A requester must drop req (or change to a new request) on the edge where it samples ack. A req still high in the IDLE cycle after DONE counts as a new request.

## Timing
- Reset (async assert, sync deassert at the system level):
  - state=IDLE, `last`=1.
  - `mem_clk1`, `mem_clk2`, `mem_rd`, `mem_wr`, `ack0`, `ack1` = 0.
  - `mem_addr`, `mem_din`, `rdata0`, `rdata1` = 0.
- Latency: request sampled at edge e0 in IDLE → `mem_clk2` high in e1–e2 → `mem_clk1` high in e3–e4 → ack high in e4–e5.
  - Ack is high during the 5th cycle after the sampling edge.
  - Throughput: one access per 6 cycles.
- Reset mid-operation aborts immediately and issues no ack.
  - Reset before STROBE: no DRAM write occurs.
  - Reset once STROBE is entered: the write is already committed, because `mem_clk1` rose.
- `rdata` never captures `mem_dout` outside STROBE. The DRAM drives X when idle, so this keeps X off the rdata registers.

## Structure
- `dram_arbiter_pkg` holds:
  - the FSM state enum (one-hot, 6 states);
  - the `PORT_FETCH`=0 and `PORT_LSU`=1 constants;
  - the default `WordSize` and `AddrWidth` localparams shared with `DRAM`.
- Sub-module `rr_arbiter2`: inputs `req[1:0]`, `last`; output one-hot `gnt[1:0]`. It is purely combinational. The pointer register stays in the parent.

## Test plan
- **Single read.**
  - Stimulus: memory preloaded with 16'h1234 at 16'h000A. Raise `req0`, `we0`=0, `addr0`=16'h000A.
  - Required: `mem_clk2` pulses with `mem_addr`=16'h000A. `ack0` pulses 5 cycles after the sampling edge with `rdata0`=16'h1234. `ack1` stays 0.
- **Write then readback.**
  - Stimulus: `req1`, `we1`=1, `addr1`=16'h0002, `wdata1`=16'h06CF. Then a read from port 1 of the same address.
  - Required: `mem_wr`=1 through CMD–DONE and `mem_rd` never set. The readback gives `rdata1`=16'h06CF.
- **Tie-break.**
  - Stimulus: `req0` and `req1` both high from reset and held through each ack.
  - Required: grants alternate 0,1,0,1. Each ack is 6 cycles apart.
- **Late request.**
  - Stimulus: `req1` rises during LATCH of a port-0 transaction.
  - Required: port 1 is serviced only after `ack0`. Its `mem_clk2` appears 3 cycles after `ack0` (DONE, IDLE, ADDR, LATCH).
- **Reset in CMD.**
  - Stimulus: write to 16'h0003 with 16'hBEEF; assert `rst_n`=0 during CMD.
  - Required: all outputs return to 0 immediately and no ack is issued. A later read of 16'h0003 returns the preload value.
- **Strobe exclusivity.**
  - Stimulus: random mixed traffic for 1000 cycles.
  - Required, checked by assertions:
    - `mem_clk1` and `mem_clk2` are never high together.
    - `mem_rd` and `mem_wr` are never high together.
    - `mem_addr` changes only in IDLE→ADDR.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// Shared definitions for the DRAM sequencer/arbiter.
//   - state_t    : one-hot sequencer states, one per DRAM access phase
//   - PORT_FETCH : requester index of the instruction-fetch port
//   - PORT_LSU   : requester index of the load/store port
//   - WORD_SIZE / ADDR_WIDTH : default widths, shared with the DRAM macro
package dram_arbiter_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int ADDR_WIDTH = 16;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_ADDR   = 6'b000010,
        S_LATCH  = 6'b000100,
        S_CMD    = 6'b001000,
        S_STROBE = 6'b010000,
        S_DONE   = 6'b100000
    } state_t;

    // RD/WR are asserted from CMD until the end of DONE.
    function automatic logic in_cmd_phase(input state_t s);
        return (s == S_CMD) || (s == S_STROBE) || (s == S_DONE);
    endfunction

endpackage

// File: rtl/dram_arbiter_rr.sv
// Two-port round-robin grant logic, purely combinational.
//   req[1:0] : request levels (index = port)
//   last     : port granted most recently (pointer kept by the parent)
//   gnt[1:0] : one-hot grant; all zero when nobody requests
module rr_arbiter2
    import dram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // A lone requester always wins; on a tie the port that did not win
    // last time is served.
    assign gnt[PORT_FETCH] = req[PORT_FETCH] & (~req[PORT_LSU]   | (last == PORT_LSU));
    assign gnt[PORT_LSU]   = req[PORT_LSU]   & (~req[PORT_FETCH] | (last == PORT_FETCH));

endmodule

// File: rtl/dram_arbiter.sv
// Sequencer and two-port round-robin arbiter for the two-phase DRAM macro.
// Each granted access walks IDLE -> ADDR -> LATCH -> CMD -> STROBE -> DONE:
// mem_clk2 latches the address, mem_clk1 performs the access, and a
// one-cycle ack is returned to the granted port (read data captured on the
// STROBE exit edge).
//   clk, rst_n          : clock, asynchronous active-low reset
//   req/we/addr/wdata 0 : instruction-fetch port request (held until ack)
//   req/we/addr/wdata 1 : load/store port request (held until ack)
//   ack0/1, rdata0/1    : completion pulse and read data per port
//   mem_*               : DRAM address, data, strobes and RD/WR
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int WordSize  = WORD_SIZE,
    parameter int AddrWidth = ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [AddrWidth-1:0] addr0,
    input  logic [AddrWidth-1:0] addr1,
    input  logic [WordSize-1:0]  wdata0,
    input  logic [WordSize-1:0]  wdata1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [WordSize-1:0]  rdata0,
    output logic [WordSize-1:0]  rdata1,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [WordSize-1:0]  mem_din,
    input  logic [WordSize-1:0]  mem_dout,
    output logic                 mem_clk1,
    output logic                 mem_clk2,
    output logic                 mem_rd,
    output logic                 mem_wr
);

    state_t state_reg, state_next;
    logic   last_reg;
    logic   sel_reg;
    logic   we_reg;
    logic [1:0] gnt;
    logic       grant_now;

    logic [1:0]                ack_vec;
    logic [1:0][WordSize-1:0]  rdata_vec;

    rr_arbiter2 u_rr (
        .req  ({req1, req0}),
        .last (last_reg),
        .gnt  (gnt)
    );

    // Requests are only looked at while idle; anything raised mid-access waits.
    assign grant_now = (state_reg == S_IDLE) && (gnt != 2'b00);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:   if (grant_now) state_next = S_ADDR;
            S_ADDR:   state_next = S_LATCH;
            S_LATCH:  state_next = S_CMD;
            S_CMD:    state_next = S_STROBE;
            S_STROBE: state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered, so each DRAM
    // control line is a clean flop output aligned with its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            last_reg  <= PORT_LSU;
            sel_reg   <= PORT_FETCH;
            we_reg    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_clk1  <= 1'b0;
            mem_clk2  <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant_now) begin
                sel_reg  <= gnt[PORT_LSU];
                last_reg <= gnt[PORT_LSU];
                we_reg   <= gnt[PORT_LSU] ? we1    : we0;
                mem_addr <= gnt[PORT_LSU] ? addr1  : addr0;
                mem_din  <= gnt[PORT_LSU] ? wdata1 : wdata0;
            end
            mem_clk2 <= (state_next == S_LATCH);
            mem_clk1 <= (state_next == S_STROBE);
            mem_rd   <= in_cmd_phase(state_next) & ~we_reg;
            mem_wr   <= in_cmd_phase(state_next) &  we_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PORT = 1'(gi);
            logic                ack_q;
            logic [WordSize-1:0] rdata_q;

            // DRAM output is only meaningful while mem_clk1 is high, so the
            // capture is restricted to the STROBE exit edge of a read.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ack_q   <= 1'b0;
                    rdata_q <= '0;
                end else begin
                    ack_q <= (state_next == S_DONE) && (sel_reg == PORT);
                    if ((state_reg == S_STROBE) && !we_reg && (sel_reg == PORT))
                        rdata_q <= mem_dout;
                end
            end

            assign ack_vec[gi]   = ack_q;
            assign rdata_vec[gi] = rdata_q;
        end
    endgenerate

    assign ack0   = ack_vec[PORT_FETCH];
    assign ack1   = ack_vec[PORT_LSU];
    assign rdata0 = rdata_vec[PORT_FETCH];
    assign rdata1 = rdata_vec[PORT_LSU];

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter with a behavioural two-phase DRAM model.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] mem_addr, mem_din, mem_dout;
    logic        mem_clk1, mem_clk2, mem_rd, mem_wr;

    dram_arbiter #(.WordSize(16), .AddrWidth(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_clk1(mem_clk1), .mem_clk2(mem_clk2), .mem_rd(mem_rd), .mem_wr(mem_wr)
    );

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] mem[256];
    logic [15:0] ref_mem[256];
    logic [15:0] last_rd[2];
    logic [15:0] addr_lat = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_ack_cyc[2];
    int          last_clk2_cyc = 0;
    bit          saw_rd = 0, saw_wr = 0;
    logic [15:0] prev_addr = '0;
    bit          prev_busy = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DRAM model: address latched by mem_clk2, access performed by mem_clk1.
    always @(posedge mem_clk2) addr_lat <= mem_addr;
    always @(posedge mem_clk1) if (mem_wr) mem[addr_lat[7:0]] <= mem_din;
    assign mem_dout = (mem_clk1 && mem_rd) ? mem[addr_lat[7:0]] : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit p, input bit we, input logic [15:0] a, input logic [15:0] wd);
        exp_t e;
        e.we   = we;
        e.addr = a;
        if (we) begin
            e.data = last_rd[p];
            ref_mem[a[7:0]] = wd;
        end else begin
            e.data = ref_mem[a[7:0]];
            last_rd[p] = e.data;
        end
        if (p) q1.push_back(e);
        else   q0.push_back(e);
    endtask

    task automatic check_ack(input bit p);
        exp_t e;
        logic [15:0] rd;
        rd = p ? rdata1 : rdata0;
        last_ack_cyc[p] = cyc;
        if ((p ? q1.size() : q0.size()) == 0) begin
            check($sformatf("p%0d_unexpected_ack", p), 32'd1, 32'd0);
        end else begin
            e = p ? q1.pop_front() : q0.pop_front();
            check($sformatf("p%0d_rdata", p), 32'(rd), 32'(e.data));
            check($sformatf("p%0d_latched_addr", p), 32'(addr_lat), 32'(e.addr));
            check($sformatf("p%0d_saw_wr", p), 32'(saw_wr), 32'(e.we));
            check($sformatf("p%0d_saw_rd", p), 32'(saw_rd), 32'(!e.we));
            $display("ack port %0d we=%0d addr=%h rdata=%h cycle %0d", p, e.we, e.addr, rd, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT acknowledges.
    always @(negedge clk) begin
        if (!rst_n) begin
            saw_rd = 0;
            saw_wr = 0;
        end else begin
            if (mem_clk2) begin
                saw_rd = 0;
                saw_wr = 0;
                last_clk2_cyc = cyc;
            end
            if (mem_rd) saw_rd = 1;
            if (mem_wr) saw_wr = 1;
            if (ack0 || ack1) check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
            if (ack0) check_ack(1'b0);
            if (ack1) check_ack(1'b1);
        end
    end

    // Protocol checker: strobe exclusivity and address stability.
    always @(negedge clk) begin
        bit now_busy;
        now_busy = mem_rd | mem_wr | mem_clk1 | mem_clk2 | ack0 | ack1;
        if (rst_n) begin
            check("clk1_clk2_excl", 32'(mem_clk1 & mem_clk2), 32'd0);
            check("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
            if (mem_addr != prev_addr)
                check("addr_change_only_idle_to_addr", 32'({prev_busy, now_busy}), 32'd0);
        end
        prev_addr = mem_addr;
        prev_busy = now_busy;
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, 32'({mem_clk1, mem_clk2, mem_rd, mem_wr, ack0, ack1}), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_din"}, 32'(mem_din), 32'd0);
        check({tag, "_rdata0"}, 32'(rdata0), 32'd0);
        check({tag, "_rdata1"}, 32'(rdata1), 32'd0);
    endtask

    // Issue one request from the current time (just after a rising edge),
    // wait for its ack and drop req on the edge that samples it.
    task automatic request(input bit p, input bit we, input logic [15:0] a,
                           input logic [15:0] wd, output int lat);
        bit got;
        push_exp(p, we, a, wd);
        if (p) begin we1 = we; addr1 = a; wdata1 = wd; req1 = 1'b1; end
        else   begin we0 = we; addr0 = a; wdata0 = wd; req0 = 1'b1; end
        lat = 0;
        got = 0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (p ? ack1 : ack0) got = 1;
        end
        if (!got) check($sformatf("p%0d_ack_timeout", p), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (p) req1 = 1'b0;
        else   req0 = 1'b0;
    endtask

    task automatic wait_any_ack(output bit p, output bit got);
        int n;
        n = 0;
        got = 0;
        p = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (ack0 || ack1) begin
                got = 1;
                p = ack1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat0, lat1, t_end, prev_cyc;
        bit p, got;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'h1000 + 16'(i);
            ref_mem[i] = 16'h1000 + 16'(i);
        end
        mem[10]     = 16'h1234;
        ref_mem[10] = 16'h1234;
        last_rd[0] = '0;
        last_rd[1] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read from the fetch port
        request(1'b0, 1'b0, 16'h000A, 16'h0000, lat);
        check("single_read_latency", 32'(lat), 32'd6);

        // Write then readback on the load/store port
        request(1'b1, 1'b1, 16'h0002, 16'h06CF, lat);
        check("write_latency", 32'(lat), 32'd6);
        request(1'b1, 1'b0, 16'h0002, 16'h0000, lat);
        check("readback_latency", 32'(lat), 32'd6);

        // Tie-break: both ports request from reset and hold through acks
        rst_n = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        we0 = 1'b0; addr0 = 16'h0010; req0 = 1'b1;
        we1 = 1'b0; addr1 = 16'h0011; req1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push_exp(1'b0, 1'b0, 16'h0010, 16'h0000);
            push_exp(1'b1, 1'b0, 16'h0011, 16'h0000);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_any_ack(p, got);
            if (!got) check("tie_ack_timeout", 32'd0, 32'd1);
            check($sformatf("tie_grant_%0d", k), 32'(p), 32'(k % 2));
            if (k > 0) check($sformatf("tie_spacing_%0d", k), 32'(cyc - prev_cyc), 32'd6);
            prev_cyc = cyc;
        end
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        #1;

        // Late request: port 1 rises while port 0 is in LATCH
        fork
            request(1'b0, 1'b0, 16'h0020, 16'h0000, lat0);
            begin
                repeat (2) @(posedge clk);
                #1;
                request(1'b1, 1'b0, 16'h0021, 16'h0000, lat1);
            end
        join
        check("late_p0_latency", 32'(lat0), 32'd6);
        check("late_p1_latency", 32'(lat1), 32'd10);
        check("late_clk2_after_ack0", 32'(last_clk2_cyc - last_ack_cyc[0]), 32'd3);

        // Reset during CMD of a write aborts it
        we1 = 1'b1; addr1 = 16'h0003; wdata1 = 16'hBEEF; req1 = 1'b1;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (mem_wr) got = 1;
        end
        check("abort_reached_cmd", 32'(got), 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        req1 = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        request(1'b1, 1'b0, 16'h0003, 16'h0000, lat);
        check("abort_readback_latency", 32'(lat), 32'd6);

        // Random mixed traffic on disjoint address windows
        t_end = cyc + 1000;
        fork
            begin : rnd0
                int l, gap;
                while (cyc < t_end) begin
                    gap = $urandom_range(0, 3);
                    if (gap > 0) begin
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                    request(1'b0, 1'($urandom_range(0, 1)), 16'(16'h0040 + $urandom_range(0, 31)),
                            16'($urandom), l);
                end
            end
            begin : rnd1
                int l, gap;
                while (cyc < t_end) begin
                    gap = $urandom_range(0, 3);
                    if (gap > 0) begin
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                    request(1'b1, 1'($urandom_range(0, 1)), 16'(16'h0060 + $urandom_range(0, 31)),
                            16'($urandom), l);
                end
            end
        join

        repeat (3) @(posedge clk);
        #1;
        check("p0_queue_drained", 32'(q0.size()), 32'd0);
        check("p1_queue_drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
